aliens_march_sched: RTL and testbench
=====================================

Name: aliens_march_sched

Overview:
- Scheduler that sequences the alien formation datapath: generates the one-cycle `motion` command (LEFT/RIGHT/DOWN) consumed by the alien motion/collision block.
- Paces steps in video frames (one `frameTick` per frame). Marches in one direction until the edge flag drops, then issues one DOWN and reverses.
- Speeds up as aliens die. Freezes permanently on victory/defeat until reset.

Parameters:
- NB_ALIENS, 4, width of `alive` bitmap
- PERIOD_W, 8, width of frame counter/period
- BASE_PERIOD, 30, frames per step when speed-up compiled out (must be >=1)
- MIN_PERIOD, 2, minimum frames per step with speed-up (must be >=1)
- SPEED_SHIFT, 0, `aliveCount` right-shift applied before adding to MIN_PERIOD

Ports:
- clk, in, 1, system clock
- reset, in, 1, synchronous, active-low reset
- run, in, 1, 1 = game running; 0 = pause (frame counting frozen)
- frameTick, in, 1, one-cycle pulse per frame
- canLeft, in, 1, formation may step left
- canRight, in, 1, formation may step right
- victory, in, 1, all aliens dead
- defeat, in, 1, formation reached bottom limit
- alive, in, NB_ALIENS, alive bitmap
- motion, out, 2, 0 none / 1 LEFT / 2 RIGHT / 3 DOWN; non-zero for exactly one cycle per step
- dirRight, out, 1, current march direction (1 = right)
- halted, out, 1, scheduler frozen
- aliveCount, out, clog2(NB_ALIENS+1), registered popcount of `alive`

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, motion=0, dirRight=1, halted=0, cnt=0, aliveCount=0.
- aliveCount: registered popcount of `alive`, 1-cycle latency.
- period: speed-up on = MIN_PERIOD + (aliveCount>>SPEED_SHIFT), saturating at 2^PERIOD_W-1; speed-up off = BASE_PERIOD.
- IDLE: motion=0. When run==1, load cnt=period-1 and go to WAIT.
- WAIT:
  - frameTick with run==0 is ignored; cnt holds.
  - frameTick with run==1 and cnt!=0: cnt<=cnt-1.
  - frameTick with run==1 and cnt==0: decide and go to ISSUE.
- Decision, using canLeft/canRight sampled in the frameTick cycle:
  - dirRight && canRight -> RIGHT
  - dirRight && !canRight -> DOWN, dirRight<=0
  - !dirRight && canLeft -> LEFT
  - !dirRight && !canLeft -> DOWN, dirRight<=1
- ISSUE: lasts exactly one cycle; `motion` is registered and holds the decided code. Next cycle: motion<=0, cnt<=period-1 (period sampled now), state=WAIT.
- Step cadence: one step every `period` accepted frameTicks. Motion appears in the cycle after the expiring frameTick.
- A period change takes effect at the next reload only; the running count is not rescaled.
- HALT: victory||defeat sampled high in any state -> HALT next cycle, motion=0, halted=1.
  - Priority over a simultaneous expiry: no motion is issued.
  - Exit only by reset.
- Both canLeft and canRight low: DOWN is issued and direction flips anyway; no deadlock.
- alive==0 with speed-up: period=MIN_PERIOD (victory halts anyway).
- Reset mid-ISSUE: motion is 0 in the next cycle.
- Simultaneous frameTick and run falling: that tick is ignored.

Optional Feature:
- Macro ALIEN_SPEEDUP_EN.
- Defined: period derives from aliveCount as above; fewer aliens give faster steps.
- Undefined: period is constant BASE_PERIOD; aliveCount is still output; MIN_PERIOD and SPEED_SHIFT are unused.

Decomposition:
- Shared package `aliens_pkg` holds:
  - motion codes MOT_NONE=0, MOT_LEFT=1, MOT_RIGHT=2, MOT_DOWN=3, also used by the alien motion block
  - FSM state encoding IDLE/WAIT/ISSUE/HALT
- Natural sub-module: `alive_popcount` (parameterised NB_ALIENS, registered output).

Test Plan:
- Speed-up off, BASE_PERIOD=3, canRight=1, run=1, 10 frameTicks -> motion=2 for one cycle after ticks 3, 6 and 9. Otherwise motion=0.
- dirRight=1, canRight drops to 0 before an expiry -> motion=3 once, dirRight=0. With canLeft=1, the next expiry gives motion=1.
- ALIEN_SPEEDUP_EN, MIN_PERIOD=2, SHIFT=0, NB_ALIENS=4:
  - alive=4'b1111 -> steps every 6 ticks.
  - Set alive=4'b0001 mid-count -> current interval finishes at 6, then steps every 3.
- defeat pulses high in the same cycle as an expiring frameTick -> no motion; halted=1 the next cycle; further ticks give no motion; reset=0 for one clock -> IDLE, dirRight=1.
- run=0 across 5 frameTicks mid-WAIT with cnt=2 -> cnt stays 2. run=1 -> step after exactly 3 more ticks.
- canLeft=canRight=0 -> DOWN issued at every expiry and dirRight toggles each time.

Source files
------------

// File: rtl/aliens_pkg.sv
// aliens_pkg: motion codes and scheduler state encoding shared by the alien formation blocks
package aliens_pkg;
  localparam logic [1:0] MOT_NONE  = 2'd0;
  localparam logic [1:0] MOT_LEFT  = 2'd1;
  localparam logic [1:0] MOT_RIGHT = 2'd2;
  localparam logic [1:0] MOT_DOWN  = 2'd3;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, HALT} state_t;
endpackage

// File: rtl/alive_popcount.sv
// alive_popcount: registered population count of the alive bitmap
// Ports: clk, reset (sync, active-low), alive [NB_ALIENS] in, count out (1-cycle latency)
module alive_popcount #(
  parameter int NB_ALIENS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NB_ALIENS-1:0]           alive,
  output logic [$clog2(NB_ALIENS+1)-1:0] count
);
  localparam int CW = $clog2(NB_ALIENS + 1);
  logic [CW-1:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < NB_ALIENS; i++) sum = sum + CW'(alive[i]);
  end
  always_ff @(posedge clk)
    if (!reset) count <= '0;
    else count <= sum;
endmodule

// File: rtl/aliens_march_sched.sv
// aliens_march_sched: paces alien formation steps in frames and issues one-cycle LEFT/RIGHT/DOWN commands
// Ports: clk; reset (sync, active-low); run (0 pauses frame counting); frameTick (1 pulse/frame);
//        canLeft/canRight (edge flags); victory/defeat (freeze until reset); alive bitmap;
//        motion (registered command, non-zero one cycle per step); dirRight; halted; aliveCount.
// Build option: ALIEN_SPEEDUP_EN derives the step period from aliveCount; otherwise BASE_PERIOD.
module aliens_march_sched
  import aliens_pkg::*;
#(
  parameter int NB_ALIENS   = 4,
  parameter int PERIOD_W    = 8,
  parameter int BASE_PERIOD = 30,
  parameter int MIN_PERIOD  = 2,
  parameter int SPEED_SHIFT = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           frameTick,
  input  logic                           canLeft,
  input  logic                           canRight,
  input  logic                           victory,
  input  logic                           defeat,
  input  logic [NB_ALIENS-1:0]           alive,
  output logic [1:0]                     motion,
  output logic                           dirRight,
  output logic                           halted,
  output logic [$clog2(NB_ALIENS+1)-1:0] aliveCount
);
  state_t state, state_n;
  logic [PERIOD_W-1:0] cnt, cnt_n, period;
  logic [1:0] motion_n;
  logic dir_n;
  if (BASE_PERIOD < 1 || MIN_PERIOD < 1 || SPEED_SHIFT < 0) begin : g_param_check
    $error("aliens_march_sched: periods must be >= 1 and SPEED_SHIFT >= 0");
  end
  alive_popcount #(.NB_ALIENS(NB_ALIENS)) u_popcount (
    .clk   (clk),
    .reset (reset),
    .alive (alive),
    .count (aliveCount)
  );
`ifdef ALIEN_SPEEDUP_EN
  localparam int PMAX = 2 ** PERIOD_W - 1;
  logic [31:0] period_raw;
  assign period_raw = 32'(MIN_PERIOD) + 32'(aliveCount >> SPEED_SHIFT);
  assign period = period_raw > 32'(PMAX) ? PERIOD_W'(PMAX) : period_raw[PERIOD_W-1:0];
`else
  assign period = PERIOD_W'(BASE_PERIOD);
`endif
  assign halted = state == HALT;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dir_n    = dirRight;
    motion_n = MOT_NONE;
    if (victory || defeat) state_n = HALT;
    else
      case (state)
        IDLE: if (run) begin
          cnt_n   = period - 1'b1;
          state_n = WAIT;
        end
        WAIT: if (frameTick && run) begin
          if (cnt != '0) cnt_n = cnt - 1'b1;
          else begin
            state_n  = ISSUE;
            motion_n = dirRight ? (canRight ? MOT_RIGHT : MOT_DOWN) : (canLeft ? MOT_LEFT : MOT_DOWN);
            dir_n    = dirRight ? canRight : !canLeft;
          end
        end
        ISSUE: begin
          cnt_n   = period - 1'b1;
          state_n = WAIT;
        end
        default: state_n = HALT;
      endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      motion   <= MOT_NONE;
      dirRight <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      motion   <= motion_n;
      dirRight <= dir_n;
    end
endmodule

// File: tb/tb_aliens_march_sched.sv
// tb_aliens_march_sched: scenario and randomized checks of the march scheduler against a tick-counting model
module tb_aliens_march_sched;
  import aliens_pkg::*;
  localparam int NB = 4, PW = 8, BP = 3, MP = 2, SS = 0;
  logic clk = 1'b0;
  logic reset, run, frameTick, canLeft, canRight, victory, defeat;
  logic [NB-1:0] alive;
  logic [1:0] motion;
  logic dirRight, halted;
  logic [2:0] aliveCount;
  int vectors = 0, miscompares = 0;
  bit m_halt, m_started, m_issue, m_dir;
  int m_n, m_p, m_alive;
  logic [1:0] m_motion;
  int diverge, steps;
  logic [1:0] last_mot;

  aliens_march_sched #(.NB_ALIENS(NB), .PERIOD_W(PW), .BASE_PERIOD(BP), .MIN_PERIOD(MP), .SPEED_SHIFT(SS)) dut (
    .clk(clk), .reset(reset), .run(run), .frameTick(frameTick), .canLeft(canLeft), .canRight(canRight),
    .victory(victory), .defeat(defeat), .alive(alive), .motion(motion), .dirRight(dirRight),
    .halted(halted), .aliveCount(aliveCount)
  );

  always #5 clk = ~clk;

  function automatic int period_of(int c);
`ifdef ALIEN_SPEEDUP_EN
    return (MP + (c >> SS) > 2 ** PW - 1) ? 2 ** PW - 1 : MP + (c >> SS);
`else
    return BP;
`endif
  endfunction

  // Model: count accepted ticks since the last reload; a step fires when the count reaches the period
  // captured at that reload. Any disagreement with the DUT is tallied in diverge.
  task automatic clk_step();
    logic [1:0] nm;
    nm = MOT_NONE;
    if (!reset) begin
      m_halt = 0; m_started = 0; m_issue = 0; m_dir = 1; m_alive = 0;
    end else begin
      if (m_halt) nm = MOT_NONE;
      else if (victory || defeat) m_halt = 1;
      else if (!m_started) begin
        if (run) begin m_started = 1; m_p = period_of(m_alive); m_n = 0; end
      end else if (m_issue) begin
        m_issue = 0; m_p = period_of(m_alive); m_n = 0;
      end else if (frameTick && run) begin
        m_n++;
        if (m_n == m_p) begin
          m_issue = 1;
          nm = m_dir ? (canRight ? MOT_RIGHT : MOT_DOWN) : (canLeft ? MOT_LEFT : MOT_DOWN);
          if (nm == MOT_DOWN) m_dir = !m_dir;
        end
      end
      m_alive = $countones(alive);
    end
    m_motion = nm;
    @(posedge clk);
    #1;
    if (motion !== m_motion || dirRight !== m_dir || halted !== m_halt || aliveCount !== 3'(m_alive)) diverge++;
    if (motion != MOT_NONE) begin steps++; last_mot = motion; end
  endtask

  task automatic frames(input int k, input int gap);
    repeat (k) begin
      frameTick = 1; clk_step(); frameTick = 0;
      repeat (gap) clk_step();
    end
  endtask

  task automatic until_step(output int n);
    steps = 0; n = 0;
    while (steps == 0 && n < 300) begin frames(1, 1); n++; end
  endtask

  task automatic test_reset();
    reset = 0; run = 0; frameTick = 0; canLeft = 0; canRight = 1; victory = 0; defeat = 0; alive = 4'b1111;
    diverge = 0;
    clk_step(); clk_step();
    vectors += 4;
    if (motion !== 2'd0) begin miscompares++; $display("FAIL reset_motion got %0d want 0", motion); end
    if (dirRight !== 1'b1) begin miscompares++; $display("FAIL reset_dir got %b want 1", dirRight); end
    if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", halted); end
    if (aliveCount !== 3'd0) begin miscompares++; $display("FAIL reset_alivecount got %0d want 0", aliveCount); end
    reset = 1;
    clk_step();
    vectors++;
    if (aliveCount !== 3'd4) begin miscompares++; $display("FAIL popcount_latency got %0d want 4", aliveCount); end
  endtask

  task automatic test_march();
    int want;
    diverge = 0; steps = 0;
    run = 1; canRight = 1;
    clk_step();
    repeat (10) frames(1, $urandom_range(1, 3));
`ifdef ALIEN_SPEEDUP_EN
    want = 1;
`else
    want = 3;
`endif
    vectors += 3;
    if (steps !== want) begin miscompares++; $display("FAIL march_steps got %0d want %0d", steps, want); end
    if (last_mot !== MOT_RIGHT) begin miscompares++; $display("FAIL march_code got %0d want 2", last_mot); end
    if (diverge !== 0) begin miscompares++; $display("FAIL march_model got %0d diverging cycles want 0", diverge); end
  endtask

  task automatic test_edge();
    int n;
    diverge = 0;
    canRight = 0; canLeft = 1;
    until_step(n);
    vectors += 2;
    if (last_mot !== MOT_DOWN) begin miscompares++; $display("FAIL edge_down got %0d want 3", last_mot); end
    if (dirRight !== 1'b0) begin miscompares++; $display("FAIL edge_dir got %b want 0", dirRight); end
    until_step(n);
    vectors += 3;
    if (last_mot !== MOT_LEFT) begin miscompares++; $display("FAIL edge_left got %0d want 1", last_mot); end
    if (n !== period_of(4)) begin miscompares++; $display("FAIL edge_period got %0d want %0d", n, period_of(4)); end
    if (diverge !== 0) begin miscompares++; $display("FAIL edge_model got %0d diverging cycles want 0", diverge); end
  endtask

  task automatic test_pause();
    int n;
    diverge = 0;
    until_step(n);
    frames(period_of(4) - 3, 1);
    run = 0; steps = 0;
    frames(5, 1);
    vectors++;
    if (steps !== 0) begin miscompares++; $display("FAIL pause_steps got %0d want 0", steps); end
    run = 1;
    until_step(n);
    vectors += 2;
    if (n !== 3) begin miscompares++; $display("FAIL pause_resume got %0d ticks want 3", n); end
    if (diverge !== 0) begin miscompares++; $display("FAIL pause_model got %0d diverging cycles want 0", diverge); end
  endtask

  task automatic test_both_blocked();
    int n;
    logic d;
    diverge = 0;
    canLeft = 0; canRight = 0;
    repeat (4) begin
      d = dirRight;
      until_step(n);
      vectors += 2;
      if (last_mot !== MOT_DOWN) begin miscompares++; $display("FAIL blocked_code got %0d want 3", last_mot); end
      if (dirRight !== !d) begin miscompares++; $display("FAIL blocked_dir got %b want %b", dirRight, !d); end
    end
    vectors++;
    if (diverge !== 0) begin miscompares++; $display("FAIL blocked_model got %0d diverging cycles want 0", diverge); end
  endtask

  task automatic test_speed();
    int n, w_first, w_next;
`ifdef ALIEN_SPEEDUP_EN
    w_first = 4; w_next = 3;
`else
    w_first = 1; w_next = 3;
`endif
    diverge = 0;
    canLeft = 1; canRight = 1; alive = 4'b1111;
    until_step(n);
    frames(2, 1);
    alive = 4'b0001;
    until_step(n);
    vectors++;
    if (n !== w_first) begin miscompares++; $display("FAIL speed_finish got %0d ticks want %0d", n, w_first); end
    repeat (2) begin
      until_step(n);
      vectors++;
      if (n !== w_next) begin miscompares++; $display("FAIL speed_fast got %0d ticks want %0d", n, w_next); end
    end
    vectors++;
    if (diverge !== 0) begin miscompares++; $display("FAIL speed_model got %0d diverging cycles want 0", diverge); end
    alive = 4'b1111;
  endtask

  task automatic test_halt();
    int n;
    diverge = 0;
    canRight = 0; canLeft = 1;
    until_step(n);
    clk_step();
    frames(m_p - 1, 1);
    frameTick = 1; defeat = 1;
    clk_step();
    frameTick = 0; defeat = 0;
    vectors += 3;
    if (motion !== 2'd0) begin miscompares++; $display("FAIL halt_motion got %0d want 0", motion); end
    if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag got %b want 1", halted); end
    if (dirRight !== 1'b0) begin miscompares++; $display("FAIL halt_dir got %b want 0", dirRight); end
    steps = 0;
    frames(10, 1);
    vectors += 2;
    if (steps !== 0) begin miscompares++; $display("FAIL halt_frozen got %0d steps want 0", steps); end
    if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_sticky got %b want 1", halted); end
    reset = 0; clk_step(); reset = 1;
    clk_step();
    vectors += 4;
    if (dirRight !== 1'b1) begin miscompares++; $display("FAIL halt_reset_dir got %b want 1", dirRight); end
    if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_reset_flag got %b want 0", halted); end
    if (motion !== 2'd0) begin miscompares++; $display("FAIL halt_reset_motion got %0d want 0", motion); end
    if (diverge !== 0) begin miscompares++; $display("FAIL halt_model got %0d diverging cycles want 0", diverge); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 12; c++) begin
      diverge = 0;
      repeat (250) begin
        reset     = $urandom_range(0, 99) != 0;
        run       = $urandom_range(0, 9) != 0;
        frameTick = $urandom_range(0, 2) == 0;
        canLeft   = $urandom_range(0, 9) < 7;
        canRight  = $urandom_range(0, 9) < 7;
        victory   = $urandom_range(0, 499) == 0;
        defeat    = $urandom_range(0, 499) == 0;
        if ($urandom_range(0, 19) == 0) alive = NB'($urandom);
        clk_step();
      end
      vectors++;
      if (diverge !== 0) begin miscompares++; $display("FAIL random_chunk%0d got %0d diverging cycles want 0", c, diverge); end
    end
  endtask

  initial begin
    test_reset();
    test_march();
    test_edge();
    test_pause();
    test_both_blocked();
    test_speed();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
